gun_crosshair_overlay: RTL and testbench

- Sits in the video path between the williams2 board RGB/blank/sync outputs and arcade_video.
- Consumes the same gun_h/gun_v position that the joystick gun integrator feeds the board, and draws a plus-shaped crosshair at the corresponding screen location.
- Gives the player visual feedback of where the board thinks the gun points.
- Flashes the crosshair on trigger.

---
 rtl/gun_overlay_pkg.sv | 35 +++
 rtl/gun_crosshair_overlay_pos.sv | 72 +++++++
 rtl/gun_crosshair_overlay.sv | 135 +++++++++++++
 tb/tb_gun_crosshair_overlay.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gun_overlay_pkg.sv
// Purpose: shared constants, types and the arm-distance helper for the gun crosshair overlay.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gun_overlay_pkg;

  // Counter widths for the pixel (x) and line (y) position counters.
  localparam int XW = 10;
  localparam int YW = 9;

  // Crosshair colours, {R,G,B}.
  localparam logic [23:0] COL_WHITE = 24'hFFFFFF;
  localparam logic [23:0] COL_RED   = 24'hFF0000;

  // Video timing bits carried alongside the pixel colour.
  typedef struct packed {
    logic hblank;
    logic vblank;
    logic hs;
    logic vs;
  } vtiming_t;

  // True when |a - b| <= lim. The difference is taken signed at XW+1 bits,
  // so positions on either side of the centre compare correctly and arms
  // running off the screen edge never wrap around to the far side.
  function automatic logic abs_le(input logic [XW-1:0] a,
                                  input logic [XW-1:0] b,
                                  input logic [3:0]    lim);
    logic signed [XW:0] diff;
    logic        [XW:0] mag;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    mag  = diff[XW] ? (-$unsigned(diff)) : $unsigned(diff);
    return mag <= {{(XW-3){1'b0}}, lim};
  endfunction

endpackage

// File: rtl/gun_crosshair_overlay_pos.sv
// Purpose: pixel/line position counters plus hblank/vblank rising-edge strobes.
// Latency: counters register on a ce tick; rise strobes are combinational against the previous ce tick.
// Backpressure: none; state only advances when ce_i is high.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   ce_i                   pixel enable
//   hblank_i, vblank_i     board blanking
//   x_o, y_o               current pixel column / line (saturating)
//   hblank_rise_o          hblank_i high now, low on the previous ce tick
//   vblank_rise_o          vblank_i high now, low on the previous ce tick
module video_pos_counter
  import gun_overlay_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ce_i,
  input  logic          hblank_i,
  input  logic          vblank_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          hblank_rise_o,
  output logic          vblank_rise_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          hb_prev_q, vb_prev_q;

  assign hblank_rise_o = hblank_i & ~hb_prev_q;
  assign vblank_rise_o = vblank_i & ~vblank_prev_unused_guard();

  // Small wrapper keeps the vblank history read in one place.
  function automatic logic vblank_prev_unused_guard();
    return vb_prev_q;
  endfunction

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    // Counters stick at all-ones rather than wrapping so an overlong line or
    // frame can never alias back onto the crosshair position.
    if (hblank_i) begin
      x_d = '0;
    end else if (x_q != '1) begin
      x_d = x_q + 1'b1;
    end
    if (vblank_i) begin
      y_d = '0;
    end else if (hblank_rise_o && (y_q != '1)) begin
      y_d = y_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      x_q       <= '0;
      y_q       <= '0;
      hb_prev_q <= 1'b0;
      vb_prev_q <= 1'b0;
    end else if (ce_i) begin
      x_q       <= x_d;
      y_q       <= y_d;
      hb_prev_q <= hblank_i;
      vb_prev_q <= vblank_i;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/gun_crosshair_overlay.sv
// Purpose: draws a plus-shaped crosshair at the latched gun position over the board video, red while flashing.
// Latency: exactly one ce_pix tick on rgb_out and all timing outputs.
// Backpressure: none; every register holds while ce_pix is low.
//
// Ports:
//   clk_48, reset_n              video clock, synchronous active-low reset
//   ce_pix                       pixel enable
//   enable                       1 = draw crosshair, 0 = pass video through
//   gun_h, gun_v                 gun position 0..63, latched at each vblank rise
//   trigger                      fire button level; a rising edge starts the red flash
//   rgb_in, *_in                 board colour and timing
//   rgb_out, *_out               overlaid colour and timing, one ce tick later
module gun_crosshair_overlay
  import gun_overlay_pkg::*;
#(
  parameter logic [9:0] X_OFS        = 10'd16,
  parameter logic [8:0] Y_OFS        = 9'd24,
  parameter logic [2:0] X_STEP       = 3'd4,
  parameter logic [2:0] Y_STEP       = 3'd3,
  parameter logic [3:0] ARM          = 4'd5,
  parameter logic [3:0] FLASH_FRAMES = 4'd8
) (
  input  logic        clk_48,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic        enable,
  input  logic [5:0]  gun_h,
  input  logic [5:0]  gun_v,
  input  logic        trigger,
  input  logic [23:0] rgb_in,
  input  logic        hblank_in,
  input  logic        vblank_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [23:0] rgb_out,
  output logic        hblank_out,
  output logic        vblank_out,
  output logic        hs_out,
  output logic        vs_out
);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          hb_rise, vb_rise;

  video_pos_counter u_pos (
    .clk_i         (clk_48),
    .rst_ni        (reset_n),
    .ce_i          (ce_pix),
    .hblank_i      (hblank_in),
    .vblank_i      (vblank_in),
    .x_o           (x),
    .y_o           (y),
    .hblank_rise_o (hb_rise),
    .vblank_rise_o (vb_rise)
  );

  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic          valid_q, valid_d;
  logic [3:0]    flash_q, flash_d;
  logic          trig_prev_q, trig_prev_d;
  logic [23:0]   rgb_q, rgb_d;
  vtiming_t      tim_q, tim_d;

  logic trig_rise;
  logic on_h, on_v, draw;

  assign trig_rise = trigger & ~trig_prev_q;

  always_comb begin
    cx_d        = cx_q;
    cy_d        = cy_q;
    valid_d     = valid_q;
    flash_d     = flash_q;
    trig_prev_d = trigger;

    // The centre only moves at the start of vertical blank, so a gun update
    // arriving mid-frame cannot tear the crosshair across two positions.
    if (vb_rise) begin
      cx_d    = X_OFS + ({4'd0, gun_h} * {7'd0, X_STEP});
      cy_d    = Y_OFS + ({3'd0, gun_v} * {6'd0, Y_STEP});
      valid_d = 1'b1;
    end

    // A fresh press reloads the flash even if it lands on a vblank rise.
    if (trig_rise) begin
      flash_d = FLASH_FRAMES;
    end else if (vb_rise && (flash_q != 4'd0)) begin
      flash_d = flash_q - 1'b1;
    end

    on_h = (y == cy_q) && abs_le(x, cx_q, ARM);
    on_v = (x == cx_q) && abs_le({1'b0, y}, {1'b0, cy_q}, ARM);
    draw = enable && valid_q && !hblank_in && !vblank_in && (on_h || on_v);

    if (draw) begin
      rgb_d = (flash_q != 4'd0) ? COL_RED : COL_WHITE;
    end else begin
      rgb_d = rgb_in;
    end

    tim_d.hblank = hblank_in;
    tim_d.vblank = vblank_in;
    tim_d.hs     = hs_in;
    tim_d.vs     = vs_in;
  end

  always_ff @(posedge clk_48) begin
    if (!reset_n) begin
      cx_q        <= '0;
      cy_q        <= '0;
      valid_q     <= 1'b0;
      flash_q     <= 4'd0;
      trig_prev_q <= 1'b0;
      rgb_q       <= '0;
      tim_q       <= '0;
    end else if (ce_pix) begin
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      valid_q     <= valid_d;
      flash_q     <= flash_d;
      trig_prev_q <= trig_prev_d;
      rgb_q       <= rgb_d;
      tim_q       <= tim_d;
    end
  end

  assign rgb_out    = rgb_q;
  assign hblank_out = tim_q.hblank;
  assign vblank_out = tim_q.vblank;
  assign hs_out     = tim_q.hs;
  assign vs_out     = tim_q.vs;

endmodule

// File: tb/tb_gun_crosshair_overlay.sv
module tb_gun_crosshair_overlay;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] RED   = 24'hFF0000;

  logic        clk_48 = 1'b0;
  logic        reset_n, ce_pix, enable, trigger;
  logic [5:0]  gun_h, gun_v;
  logic [23:0] rgb_in;
  logic        hblank_in, vblank_in, hs_in, vs_in;

  logic [23:0] rgb_out_a, rgb_out_b;
  logic        hb_a, vb_a, hs_a, vs_a;
  logic        hb_b, vb_b, hs_b, vs_b;

  gun_crosshair_overlay dut_a (
    .clk_48(clk_48), .reset_n(reset_n), .ce_pix(ce_pix), .enable(enable),
    .gun_h(gun_h), .gun_v(gun_v), .trigger(trigger), .rgb_in(rgb_in),
    .hblank_in(hblank_in), .vblank_in(vblank_in), .hs_in(hs_in), .vs_in(vs_in),
    .rgb_out(rgb_out_a), .hblank_out(hb_a), .vblank_out(vb_a), .hs_out(hs_a), .vs_out(vs_a)
  );

  gun_crosshair_overlay #(.X_OFS(10'd2)) dut_b (
    .clk_48(clk_48), .reset_n(reset_n), .ce_pix(ce_pix), .enable(enable),
    .gun_h(gun_h), .gun_v(gun_v), .trigger(trigger), .rgb_in(rgb_in),
    .hblank_in(hblank_in), .vblank_in(vblank_in), .hs_in(hs_in), .vs_in(vs_in),
    .rgb_out(rgb_out_b), .hblank_out(hb_b), .vblank_out(vb_b), .hs_out(hs_b), .vs_out(vs_b)
  );

  always #5 clk_48 = ~clk_48;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: screen position comes from the stimulus generator's
  // own pixel/line indices; centre, visibility and flash follow the rules.
  int m_vb_prev, m_trig_prev, m_valid, m_cxa, m_cxb, m_cy, m_flash;
  logic [23:0] e_rgb_a, e_rgb_b;
  logic [3:0]  e_tim;

  // Per-frame statistics observed at the DUT outputs.
  int cnt_a, red_a, cnt_b, hi_b;
  int minx_a, maxx_a, miny_a, maxy_a, minx_b, maxx_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_rgb_a"}, {8'd0, rgb_out_a}, {8'd0, e_rgb_a});
    check({tag, "_rgb_b"}, {8'd0, rgb_out_b}, {8'd0, e_rgb_b});
    check({tag, "_tim_a"}, {28'd0, hb_a, vb_a, hs_a, vs_a}, {28'd0, e_tim});
    check({tag, "_tim_b"}, {28'd0, hb_b, vb_b, hs_b, vs_b}, {28'd0, e_tim});
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit hit(input int x, input int y, input int cx, input int cy);
    return ((y == cy) && (iabs(x - cx) <= 5)) || ((x == cx) && (iabs(y - cy) <= 5));
  endfunction

  task automatic model_reset();
    m_vb_prev = 0; m_trig_prev = 0; m_valid = 0; m_flash = 0;
    m_cxa = 0; m_cxb = 0; m_cy = 0;
    e_rgb_a = '0; e_rgb_b = '0; e_tim = '0;
  endtask

  task automatic tick(input bit hb, input bit vb, input bit hs, input bit vs,
                      input int px, input int ln);
    logic [23:0] rin;
    bit dr_a, dr_b, vrise, trise;
    int xs, ys;
    if ($urandom_range(0, 7) == 0) begin
      @(negedge clk_48);
      ce_pix    = 1'b0;
      rgb_in    = 24'($urandom);
      hblank_in = 1'($urandom);
      hs_in     = 1'($urandom);
      @(posedge clk_48); #1;
      check_outputs("hold");
    end
    @(negedge clk_48);
    rin = 24'($urandom);
    ce_pix = 1'b1; rgb_in = rin;
    hblank_in = hb; vblank_in = vb; hs_in = hs; vs_in = vs;
    xs = (px > 1023) ? 1023 : px;
    ys = (ln > 511) ? 511 : ln;
    dr_a = enable && (m_valid != 0) && !hb && !vb && hit(xs, ys, m_cxa, m_cy);
    dr_b = enable && (m_valid != 0) && !hb && !vb && hit(xs, ys, m_cxb, m_cy);
    e_rgb_a = dr_a ? ((m_flash != 0) ? RED : WHITE) : rin;
    e_rgb_b = dr_b ? ((m_flash != 0) ? RED : WHITE) : rin;
    e_tim   = {hb, vb, hs, vs};
    vrise = vb && (m_vb_prev == 0);
    trise = trigger && (m_trig_prev == 0);
    if (vrise) begin
      m_cxa = 16 + int'(gun_h) * 4;
      m_cxb = 2 + int'(gun_h) * 4;
      m_cy  = 24 + int'(gun_v) * 3;
      m_valid = 1;
    end
    if (trise) m_flash = 8;
    else if (vrise && m_flash > 0) m_flash--;
    m_vb_prev = vb ? 1 : 0;
    m_trig_prev = trigger ? 1 : 0;
    @(posedge clk_48); #1;
    check_outputs("pix");
    if (rgb_out_a !== rin && (rgb_out_a === WHITE || rgb_out_a === RED)) begin
      cnt_a++;
      if (rgb_out_a === RED) red_a++;
      if (px < minx_a) minx_a = px;
      if (px > maxx_a) maxx_a = px;
      if (ln < miny_a) miny_a = ln;
      if (ln > maxy_a) maxy_a = ln;
    end
    if (rgb_out_b !== rin && (rgb_out_b === WHITE || rgb_out_b === RED)) begin
      cnt_b++;
      if (px >= 1021) hi_b++;
      if (px < minx_b) minx_b = px;
      if (px > maxx_b) maxx_b = px;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_48);
    reset_n = 1'b0; ce_pix = 1'b0;
    repeat (3) @(posedge clk_48);
    #1;
    model_reset();
    check_outputs("midreset");
    @(negedge clk_48);
    reset_n = 1'b1; ce_pix = 1'b0;
  endtask

  // One frame: L active lines (width ws, or wl on lines la..lb), each
  // followed by 4 hblank pixels, then 2 vblank lines.
  // trig_mode: 0 leave trigger alone, 1 one-tick pulse on line 2, 2 raise on line 2 and hold.
  task automatic frame(input int L, input int ws, input int wl, input int la, input int lb,
                       input int chg_line, input int rst_line, input int trig_mode);
    int w;
    cnt_a = 0; red_a = 0; cnt_b = 0; hi_b = 0;
    minx_a = 9999; maxx_a = -1; miny_a = 9999; maxy_a = -1;
    minx_b = 9999; maxx_b = -1;
    for (int ln = 0; ln < L; ln++) begin
      w = (ln >= la && ln <= lb) ? wl : ws;
      if (ln == chg_line) gun_h = 6'd40;
      if (ln == rst_line) do_reset();
      for (int px = 0; px < w; px++) begin
        if (trig_mode == 1) trigger = (ln == 2 && px == 0);
        else if (trig_mode == 2 && ln == 2) trigger = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, px, ln);
      end
      for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, (k == 1 || k == 2), 1'b0, -1, ln);
    end
    for (int v = 0; v < 2; v++)
      for (int k = 0; k < 8; k++) tick((k >= 4), 1'b1, (k == 5), (v == 0), -1, -1);
  endtask

  initial begin
    reset_n = 1'b0; ce_pix = 1'b0; enable = 1'b1; trigger = 1'b0;
    gun_h = 6'd10; gun_v = 6'd20; rgb_in = '0;
    hblank_in = 1'b0; vblank_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_48);
    #1;
    check_outputs("reset");
    @(negedge clk_48);
    reset_n = 1'b1;

    // Defaults, gun (10,20): hidden in the first frame, centre (56,84) next.
    frame(92, 16, 64, 75, 92, -1, -1, 0);
    check("d1_cnt", cnt_a, 0);
    frame(92, 16, 64, 75, 92, -1, -1, 0);
    check("d2_cnt", cnt_a, 21);
    check("d2_red", red_a, 0);
    check("d2_minx", minx_a, 51);
    check("d2_maxx", maxx_a, 61);
    check("d2_miny", miny_a, 79);
    check("d2_maxy", maxy_a, 89);

    // gun_h 10 -> 40 on line 50, before the crosshair lines.
    frame(104, 16, 184, 75, 92, 50, -1, 0);
    check("m1_cnt", cnt_a, 21);
    check("m1_minx", minx_a, 51);
    check("m1_maxx", maxx_a, 61);
    frame(104, 16, 184, 75, 92, -1, -1, 0);
    check("m2_cnt", cnt_a, 21);
    check("m2_minx", minx_a, 171);
    check("m2_maxx", maxx_a, 181);

    // gun (0,0) with one 1030-pixel line at y=24; dut_b has X_OFS=2.
    gun_h = 6'd0; gun_v = 6'd0;
    frame(30, 24, 1030, 24, 24, -1, -1, 0);
    frame(30, 24, 1030, 24, 24, -1, -1, 0);
    check("c_cnt_a", cnt_a, 21);
    check("c_minx_a", minx_a, 11);
    check("c_maxx_a", maxx_a, 21);
    check("c_miny_a", miny_a, 19);
    check("c_maxy_a", maxy_a, 29);
    check("c_cnt_b", cnt_b, 18);
    check("c_minx_b", minx_b, 0);
    check("c_maxx_b", maxx_b, 7);
    check("c_far_b", hi_b, 0);

    // enable=0 for a frame, then straight back on.
    enable = 1'b0;
    frame(30, 24, 24, 0, -1, -1, -1, 0);
    check("e0_cnt_a", cnt_a, 0);
    check("e0_cnt_b", cnt_b, 0);
    enable = 1'b1;
    frame(30, 24, 24, 0, -1, -1, -1, 0);
    check("e1_cnt_a", cnt_a, 21);

    // One-tick trigger pulse: 8 red frames, then white.
    for (int f = 0; f < 10; f++) begin
      frame(30, 24, 24, 0, -1, -1, -1, (f == 0) ? 1 : 0);
      check($sformatf("pulse_red_f%0d", f), red_a, (f < 8) ? 21 : 0);
      check($sformatf("pulse_cnt_f%0d", f), cnt_a, 21);
    end

    // Trigger held for 20 frames: still only 8 red frames.
    for (int f = 0; f < 21; f++) begin
      frame(30, 24, 24, 0, -1, -1, -1, (f == 0) ? 2 : 0);
      if (f == 19) trigger = 1'b0;
      check($sformatf("hold_red_f%0d", f), red_a, (f < 8) ? 21 : 0);
    end

    // Reset on line 5: hidden for the rest of the frame, back next frame.
    frame(30, 24, 24, 0, -1, -1, 5, 0);
    check("r1_cnt", cnt_a, 0);
    frame(30, 24, 24, 0, -1, -1, -1, 0);
    check("r2_cnt", cnt_a, 21);
    check("r2_red", red_a, 0);
    check("r2_minx", minx_a, 11);
    check("r2_maxx", maxx_a, 21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
